// File: rtl/frogger_pkg.sv
// Shared move codes, PS/2 set-2 scancodes and decoder state type for the frog input path.
package frogger_pkg;

    localparam logic [2:0] MOVE_NONE  = 3'd0;
    localparam logic [2:0] MOVE_UP    = 3'd1;
    localparam logic [2:0] MOVE_DOWN  = 3'd2;
    localparam logic [2:0] MOVE_LEFT  = 3'd3;
    localparam logic [2:0] MOVE_RIGHT = 3'd4;
    localparam logic [2:0] MOVE_START = 3'd5;

    localparam logic [7:0] SC_EXT     = 8'hE0;
    localparam logic [7:0] SC_BRK     = 8'hF0;
    localparam logic [7:0] SC_UP      = 8'h1D;
    localparam logic [7:0] SC_DOWN    = 8'h1B;
    localparam logic [7:0] SC_LEFT    = 8'h1C;
    localparam logic [7:0] SC_RIGHT   = 8'h23;
    localparam logic [7:0] SC_START   = 8'h29;
    localparam logic [7:0] SC_X_UP    = 8'h75;
    localparam logic [7:0] SC_X_DOWN  = 8'h72;
    localparam logic [7:0] SC_X_LEFT  = 8'h6B;
    localparam logic [7:0] SC_X_RIGHT = 8'h74;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_EXT     = 2'd1,
        ST_BRK     = 2'd2,
        ST_EXT_BRK = 2'd3
    } state_e;

    function automatic logic [2:0] plain_map(input logic [7:0] sc);
        case (sc)
            SC_UP:    plain_map = MOVE_UP;
            SC_DOWN:  plain_map = MOVE_DOWN;
            SC_LEFT:  plain_map = MOVE_LEFT;
            SC_RIGHT: plain_map = MOVE_RIGHT;
            SC_START: plain_map = MOVE_START;
            default:  plain_map = MOVE_NONE;
        endcase
    endfunction

    function automatic logic [2:0] ext_map(input logic [7:0] sc);
        case (sc)
            SC_X_UP:    ext_map = MOVE_UP;
            SC_X_DOWN:  ext_map = MOVE_DOWN;
            SC_X_LEFT:  ext_map = MOVE_LEFT;
            SC_X_RIGHT: ext_map = MOVE_RIGHT;
            default:    ext_map = MOVE_NONE;
        endcase
    endfunction

endpackage

// File: rtl/move_fifo.sv
// Shallow move-code FIFO; a push into a full queue is accepted only when a pop frees a slot the same cycle.
module move_fifo #(
    parameter int DEPTH = 4
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     push,
    input  logic [2:0]               push_data,
    input  logic                     pop,
    output logic [2:0]               head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);

    logic [2:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [AW:0]   cnt_q, cnt_d;
    logic          do_push, do_pop;

    assign full    = (cnt_q == (AW+1)'(DEPTH));
    assign empty   = (cnt_q == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign head    = mem_q[rd_q];
    assign count   = cnt_q;

    always_comb begin
        wr_d  = do_push ? wr_q + AW'(1) : wr_q;
        rd_d  = do_pop  ? rd_q + AW'(1) : rd_q;
        cnt_d = cnt_q;
        case ({do_push, do_pop})
            2'b10:   cnt_d = cnt_q + (AW+1)'(1);
            2'b01:   cnt_d = cnt_q - (AW+1)'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge clock) begin
        if (do_push) mem_q[wr_q] <= push_data;
    end

endmodule

// File: rtl/ps2_move_decoder.sv
// PS/2 set-2 scancode parser feeding frog moves into move_fifo.
// Optional typematic-repeat filter enabled by defining PS2_MOVE_REPEAT_FILTER_EN.
module ps2_move_decoder
    import frogger_pkg::*;
#(
    parameter int DEPTH          = 4,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     key_pressed,
    input  logic [7:0]               key_data,
    input  logic                     move_ready,
    output logic                     move_valid,
    output logic [2:0]               move_code,
    output logic [$clog2(DEPTH):0]   move_count,
    output logic                     overflow
);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    state_e        state_q, state_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic          overflow_q, overflow_d;
    logic          make;
    logic [2:0]    make_code;
    logic          emit;
    logic [2:0]    plain_code, ext_code, fifo_head;
    logic          fifo_full, fifo_empty;

    assign plain_code = plain_map(key_data);
    assign ext_code   = ext_map(key_data);

    always_comb begin
        state_d   = state_q;
        tmo_d     = '0;
        make      = 1'b0;
        make_code = MOVE_NONE;
        if (key_pressed) begin
            case (state_q)
                ST_IDLE: begin
                    if (key_data == SC_EXT)      state_d = ST_EXT;
                    else if (key_data == SC_BRK) state_d = ST_BRK;
                    else if (plain_code != MOVE_NONE) begin
                        make      = 1'b1;
                        make_code = plain_code;
                    end
                end
                ST_EXT: begin
                    if (key_data == SC_BRK)      state_d = ST_EXT_BRK;
                    else if (key_data == SC_EXT) state_d = ST_EXT;
                    else begin
                        state_d   = ST_IDLE;
                        make      = (ext_code != MOVE_NONE);
                        make_code = ext_code;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end else if (state_q != ST_IDLE) begin
            // An abandoned prefix (e.g. lost byte) must not poison the next key.
            if (tmo_q == TW'(TIMEOUT_CYCLES)) state_d = ST_IDLE;
            else                              tmo_d   = tmo_q + TW'(1);
        end
    end

`ifdef PS2_MOVE_REPEAT_FILTER_EN
    logic [2:0] held_q, held_d;
    logic       brk;
    logic [2:0] brk_code;

    always_comb begin
        brk      = key_pressed && (state_q == ST_BRK || state_q == ST_EXT_BRK);
        brk_code = (state_q == ST_BRK) ? plain_code : ext_code;
        emit     = make && (make_code != held_q);
        held_d   = held_q;
        if (emit)                                                held_d = make_code;
        else if (brk && brk_code == held_q && held_q != MOVE_NONE) held_d = MOVE_NONE;
    end

    always_ff @(posedge clock) begin
        if (reset) held_q <= MOVE_NONE;
        else       held_q <= held_d;
    end
`else
    assign emit = make;
`endif

    assign overflow_d = overflow_q || (emit && fifo_full && !move_ready);

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            tmo_q      <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            tmo_q      <= tmo_d;
            overflow_q <= overflow_d;
        end
    end

    move_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (emit),
        .push_data (make_code),
        .pop       (move_ready),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (move_count)
    );

    assign move_valid = !fifo_empty;
    assign move_code  = fifo_empty ? MOVE_NONE : fifo_head;
    assign overflow   = overflow_q;

endmodule

// File: tb/tb_ps2_move_decoder.sv
// Directed bench for ps2_move_decoder (short timeout so the abandon path is reachable quickly).
module tb_ps2_move_decoder;
    import frogger_pkg::*;

    localparam int DEPTH = 4;
    localparam int TMO   = 8;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       key_pressed = 1'b0;
    logic [7:0] key_data = 8'h00;
    logic       move_ready = 1'b0;
    logic       move_valid;
    logic [2:0] move_code;
    logic [2:0] move_count;
    logic       overflow;

    int checks = 0;
    int failures = 0;

    ps2_move_decoder #(.DEPTH(DEPTH), .TIMEOUT_CYCLES(TMO)) dut (
        .clock       (clock),
        .reset       (reset),
        .key_pressed (key_pressed),
        .key_data    (key_data),
        .move_ready  (move_ready),
        .move_valid  (move_valid),
        .move_code   (move_code),
        .move_count  (move_count),
        .overflow    (overflow)
    );

    always #5 clock = ~clock;

    initial begin
        #200us;
        $display("FAIL time_limit observed=expired expected=finish");
        $fatal(1, "time limit");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
            $error("check %s", tag);
        end
    endtask

    // All helpers start and end on a negedge.
    task automatic send(input logic [7:0] b);
        key_pressed = 1'b1;
        key_data    = b;
        @(negedge clock);
        key_pressed = 1'b0;
    endtask

    task automatic pop1();
        move_ready = 1'b1;
        @(negedge clock);
        move_ready = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
    endtask

    initial begin
        @(negedge clock);
        @(negedge clock);
        chk("rst_valid", 32'(move_valid), 0);
        chk("rst_code", 32'(move_code), 0);
        chk("rst_count", 32'(move_count), 0);
        chk("rst_ovf", 32'(overflow), 0);
        reset = 1'b0;

        // Extended up, then a single pop
        send(SC_EXT); send(SC_X_UP);
        chk("ext_up_valid", 32'(move_valid), 1);
        chk("ext_up_code", 32'(move_code), 1);
        pop1();
        chk("ext_up_pop_valid", 32'(move_valid), 0);
        chk("ext_up_pop_code", 32'(move_code), 0);
        pop1();
        chk("pop_empty_count", 32'(move_count), 0);

        // Break sequences produce nothing
        do_reset();
        send(SC_EXT); send(SC_BRK); send(SC_X_UP);
        send(SC_BRK); send(SC_LEFT);
        send(8'hAA); send(8'hFA);
        chk("brk_count", 32'(move_count), 0);
        chk("brk_state", 32'(dut.state_q), 32'(ST_IDLE));
        send(SC_EXT); send(8'h12);
        chk("ext_other_count", 32'(move_count), 0);
        chk("ext_other_state", 32'(dut.state_q), 32'(ST_IDLE));

        // Overflow on fifth move, then drain in order
        do_reset();
        send(SC_UP); send(SC_DOWN); send(SC_LEFT); send(SC_RIGHT);
        chk("fill_count4", 32'(move_count), 4);
        chk("fill_ovf0", 32'(overflow), 0);
        send(SC_START);
        chk("ovf_count", 32'(move_count), 4);
        chk("ovf_flag", 32'(overflow), 1);
        for (int i = 1; i <= 4; i++) begin
            chk($sformatf("drain_%0d", i), 32'(move_code), 32'(i));
            pop1();
        end
        chk("drain_valid", 32'(move_valid), 0);
        chk("drain_code", 32'(move_code), 0);
        chk("ovf_sticky", 32'(overflow), 1);

        // Push and pop together while full
        do_reset();
        send(SC_UP); send(SC_DOWN); send(SC_LEFT); send(SC_RIGHT);
        move_ready = 1'b1;
        send(SC_START);
        move_ready = 1'b0;
        chk("pp_count", 32'(move_count), 4);
        chk("pp_ovf", 32'(overflow), 0);
        for (int i = 2; i <= 5; i++) begin
            chk($sformatf("pp_drain_%0d", i), 32'(move_code), 32'(i));
            pop1();
        end
        chk("pp_empty", 32'(move_valid), 0);

        // Typematic repeat
        do_reset();
        send(SC_UP); send(SC_UP); send(SC_UP);
        send(SC_BRK); send(SC_UP); send(SC_UP);
`ifdef PS2_MOVE_REPEAT_FILTER_EN
        chk("repeat_count", 32'(move_count), 2);
`else
        chk("repeat_count", 32'(move_count), 4);
`endif
        chk("repeat_code", 32'(move_code), 32'(MOVE_UP));
        chk("repeat_ovf", 32'(overflow), 0);

        // Timeout boundary: TMO idle cycles still completes, TMO+1 abandons
        do_reset();
        send(SC_EXT);
        repeat (TMO) @(negedge clock);
        send(SC_X_DOWN);
        chk("tmo_edge_count", 32'(move_count), 1);
        chk("tmo_edge_code", 32'(move_code), 32'(MOVE_DOWN));
        do_reset();
        send(SC_EXT);
        repeat (TMO + 1) @(negedge clock);
        chk("tmo_state", 32'(dut.state_q), 32'(ST_IDLE));
        send(SC_X_UP);
        chk("tmo_count", 32'(move_count), 0);

        // Reset mid-sequence with a queued move
        do_reset();
        send(SC_EXT); send(SC_X_LEFT);
        send(SC_EXT);
        do_reset();
        send(SC_X_UP);
        chk("midrst_valid", 32'(move_valid), 0);
        chk("midrst_code", 32'(move_code), 0);
        chk("midrst_count", 32'(move_count), 0);
        chk("midrst_ovf", 32'(overflow), 0);
        chk("midrst_state", 32'(dut.state_q), 32'(ST_IDLE));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
